// File: rtl/mvu_nloop_agu.sv
// N-level nested-loop address generator: base + signed per-level jumps, per-level lengths.
// Latency: first beat is valid 1 cycle after start; then one beat per cycle.
// Backpressure: valid/ready; while valid_o && !ready_i the address, flags and counters hold.
module mvu_nloop_agu #(
  parameter int NLOOPS  = 5,
  parameter int BADDR   = 15,
  parameter int BJUMP   = 15,
  parameter int BLENGTH = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic                      clear_i,
  input  logic [BADDR-1:0]          base_i,
  input  logic [NLOOPS*BJUMP-1:0]   jump_i,
  input  logic [NLOOPS*BLENGTH-1:0] length_i,
  output logic [BADDR-1:0]          addr_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [NLOOPS-1:0]         z_o,
  output logic                      last_o,
  output logic                      busy_o,
  output logic                      done_o
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [BADDR-1:0]    addr_q, addr_d;
  logic [BLENGTH-1:0]  cnt_q  [NLOOPS];
  logic [BLENGTH-1:0]  cnt_d  [NLOOPS];
  logic [BLENGTH-1:0]  len_q  [NLOOPS];
  logic [BLENGTH-1:0]  len_d  [NLOOPS];
  logic [BJUMP-1:0]    jump_q [NLOOPS];
  logic [BJUMP-1:0]    jump_d [NLOOPS];
  logic                done_q, done_d;
  logic                fire;
  logic                found;
  logic [BJUMP-1:0]    jsel;
  logic [BADDR-1:0]    jext;
  logic                zacc;

  assign valid_o = (state_q == RUN);
  assign fire    = valid_o && ready_i;
  assign addr_o  = addr_q;
  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_q;

  // Loop-end flags: level i ends when it and every inner level have run out.
  always_comb begin
    zacc = 1'b1;
    z_o  = '0;
    for (int i = 0; i < NLOOPS; i++) begin
      zacc   = zacc && (cnt_q[i] == '0);
      z_o[i] = valid_o && zacc;
    end
    last_o = z_o[NLOOPS-1];
  end

  // Next-state: latch on start, step the lowest non-exhausted level on each fire.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    jump_d  = jump_q;
    done_d  = 1'b0;
    found   = 1'b0;
    jsel    = '0;
    jext    = '0;
    if (clear_i) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (start_i) begin
        for (int i = 0; i < NLOOPS; i++) begin
          len_d[i]  = length_i[i*BLENGTH +: BLENGTH];
          cnt_d[i]  = length_i[i*BLENGTH +: BLENGTH];
          jump_d[i] = jump_i[i*BJUMP +: BJUMP];
        end
        addr_d  = base_i;
        state_d = RUN;
      end
    end else if (fire) begin
      // Levels below the stepping one are exactly those already at zero; they reload.
      for (int i = 0; i < NLOOPS; i++) begin
        if (!found) begin
          if (cnt_q[i] != '0) begin
            found    = 1'b1;
            cnt_d[i] = cnt_q[i] - BLENGTH'(1);
            jsel     = jump_q[i];
          end else begin
            cnt_d[i] = len_q[i];
          end
        end
      end
      for (int b = 0; b < BADDR; b++) begin
        jext[b] = jsel[(b < BJUMP) ? b : BJUMP-1];
      end
      if (found) begin
        addr_d = addr_q + jext;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  // State, address, counters and latched configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < NLOOPS; i++) begin
        cnt_q[i]  <= '0;
        len_q[i]  <= '0;
        jump_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      for (int i = 0; i < NLOOPS; i++) begin
        cnt_q[i]  <= cnt_d[i];
        len_q[i]  <= len_d[i];
        jump_q[i] <= jump_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mvu_nloop_agu.sv
module tb_mvu_nloop_agu;

  localparam int NL = 2;
  localparam int BA = 15;

  typedef struct packed {
    logic [BA-1:0] addr;
    logic [NL-1:0] z;
    logic          last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start_i, clear_i, ready_i;
  logic [BA-1:0]   base_i;
  logic [NL*15-1:0] jump_i, length_i;
  logic [BA-1:0]   addr_o;
  logic            valid_o, last_o, busy_o, done_o;
  logic [NL-1:0]   z_o;

  beat_t sb[$];
  int    n_cmp  = 0;
  int    n_err  = 0;
  int    n_fire = 0;

  always #5 clk = ~clk;

  mvu_nloop_agu #(.NLOOPS(NL), .BADDR(BA), .BJUMP(15), .BLENGTH(15)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .clear_i(clear_i),
    .base_i(base_i), .jump_i(jump_i), .length_i(length_i),
    .addr_o(addr_o), .valid_o(valid_o), .ready_i(ready_i),
    .z_o(z_o), .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
  );

  // Scoreboard monitor: every accepted beat must match the next expected beat.
  always @(negedge clk) begin
    if (rst_n && valid_o && ready_i && !clear_i) begin
      beat_t e;
      n_fire++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_beat: addr=%h z=%b last=%b, none expected", addr_o, z_o, last_o);
      end else begin
        e = sb.pop_front();
        if ({addr_o, z_o, last_o} !== {e.addr, e.z, e.last}) begin
          n_err++;
          $display("FAIL beat: got addr=%h z=%b last=%b, want addr=%h z=%b last=%b",
                   addr_o, z_o, last_o, e.addr, e.z, e.last);
        end
      end
    end
  end

  // Reference walk: inner level steps by j0, level 1 steps by j1 once inner is exhausted.
  task automatic push_walk(input logic [BA-1:0] base, input logic [14:0] j0, input logic [14:0] j1,
                           input int l0, input int l1);
    logic [BA-1:0] a;
    logic z0, z1;
    a = base;
    for (int i1 = 0; i1 <= l1; i1++) begin
      for (int i0 = 0; i0 <= l0; i0++) begin
        z0 = (i0 == l0);
        z1 = z0 && (i1 == l1);
        sb.push_back('{addr: a, z: {z1, z0}, last: z1});
        if (!z1) a = (i0 == l0) ? a + j1 : a + j0;
      end
    end
  endtask

  task automatic drive_start(input logic [BA-1:0] base, input logic [14:0] j0, input logic [14:0] j1,
                             input logic [14:0] l0, input logic [14:0] l1);
    base_i   = base;
    jump_i   = {j1, j0};
    length_i = {l1, l0};
    start_i  = 1'b1;
    @(posedge clk); #1;
    start_i  = 1'b0;
    base_i   = '0;
    jump_i   = '0;
    length_i = '0;
  endtask

  task automatic wait_size(input int target, input string name);
    for (int c = 0; c < 300 && sb.size() > target; c++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (sb.size() > target) begin
      n_err++;
      $display("FAIL %s_timeout: %0d beats outstanding, want %0d", name, sb.size(), target);
    end
  endtask

  // Called in the cycle right after the final fire.
  task automatic check_done(input string name);
    n_cmp++;
    if ({done_o, busy_o, valid_o} !== 3'b100) begin
      n_err++;
      $display("FAIL %s_done: done/busy/valid=%b, want 100", name, {done_o, busy_o, valid_o});
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s_done_pulse: done=%b one cycle later, want 0", name, done_o);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_i = 1'b0; clear_i = 1'b0; ready_i = 1'b1;
    base_i = '0; jump_i = '0; length_i = '0;
    #12;
    n_cmp++;
    if ({addr_o, valid_o, z_o, last_o, busy_o, done_o} !== '0) begin
      n_err++;
      $display("FAIL reset: addr=%h valid=%b z=%b last=%b busy=%b done=%b, want all 0",
               addr_o, valid_o, z_o, last_o, busy_o, done_o);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    n_fire = 0;
    push_walk(15'd10, 15'd1, 15'd5, 2, 1);
    drive_start(15'd10, 15'd1, 15'd5, 15'd2, 15'd1);
    wait_size(0, "basic");
    check_done("basic");
    n_cmp++;
    if (n_fire != 6) begin
      n_err++;
      $display("FAIL basic_fires: got %0d, want 6", n_fire);
    end
  endtask

  task automatic test_wrap;
    push_walk(15'd0, 15'h7FFF, 15'd0, 2, 0);
    drive_start(15'd0, 15'h7FFF, 15'd0, 15'd2, 15'd0);
    wait_size(0, "wrap");
    check_done("wrap");
  endtask

  task automatic test_backpressure;
    int c;
    n_fire = 0;
    push_walk(15'd10, 15'd1, 15'd5, 2, 1);
    drive_start(15'd10, 15'd1, 15'd5, 15'd2, 15'd1);
    c = 0;
    while (!(valid_o && addr_o == 15'd10) && c < 20) begin @(negedge clk); c++; end
    @(posedge clk); #1;
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({valid_o, addr_o, z_o, last_o} !== {1'b1, 15'd11, 2'b00, 1'b0}) begin
        n_err++;
        $display("FAIL bp_hold%0d: valid=%b addr=%h z=%b last=%b, want 1 000b 00 0",
                 i, valid_o, addr_o, z_o, last_o);
      end
    end
    @(posedge clk); #1;
    ready_i = 1'b1;
    wait_size(0, "bp");
    check_done("bp");
    n_cmp++;
    if (n_fire != 6) begin
      n_err++;
      $display("FAIL bp_fires: got %0d, want 6", n_fire);
    end
  endtask

  task automatic test_degenerate;
    push_walk(15'h1234, 15'd7, 15'd9, 0, 0);
    drive_start(15'h1234, 15'd7, 15'd9, 15'd0, 15'd0);
    wait_size(0, "degen");
    check_done("degen");
  endtask

  task automatic test_abort;
    int c;
    push_walk(15'd10, 15'd1, 15'd5, 2, 1);
    void'(sb.pop_back()); void'(sb.pop_back()); void'(sb.pop_back()); void'(sb.pop_back());
    drive_start(15'd10, 15'd1, 15'd5, 15'd2, 15'd1);
    c = 0;
    while (!(valid_o && addr_o == 15'd11) && c < 20) begin @(negedge clk); c++; end
    @(posedge clk); #1;
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    n_cmp++;
    if ({valid_o, z_o, busy_o, done_o, 5'(sb.size())} !== '0) begin
      n_err++;
      $display("FAIL abort: valid=%b z=%b busy=%b done=%b left=%0d, want all 0",
               valid_o, z_o, busy_o, done_o, sb.size());
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done_o !== 1'b0) begin
      n_err++;
      $display("FAIL abort_nodone: done=%b, want 0", done_o);
    end
    // Restart at 40, with a stray start carrying different settings mid-walk.
    push_walk(15'd40, 15'd1, 15'd5, 2, 1);
    drive_start(15'd40, 15'd1, 15'd5, 15'd2, 15'd1);
    @(posedge clk); #1;
    base_i = 15'd99; jump_i = {15'd3, 15'd3}; length_i = {15'd4, 15'd4};
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_size(0, "restart");
    check_done("restart");
  endtask

  task automatic test_back_to_back;
    push_walk(15'd100, 15'd2, 15'd10, 1, 1);
    push_walk(15'd200, 15'h7FFE, 15'd0, 2, 0);
    drive_start(15'd100, 15'd2, 15'd10, 15'd1, 15'd1);
    wait_size(3, "b2b_first");
    n_cmp++;
    if (done_o !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_done: done=%b, want 1", done_o);
    end
    drive_start(15'd200, 15'h7FFE, 15'd0, 15'd2, 15'd0);
    wait_size(0, "b2b_second");
    check_done("b2b");
  endtask

  task automatic test_reset_mid_run;
    int c;
    push_walk(15'd10, 15'd1, 15'd5, 2, 1);
    drive_start(15'd10, 15'd1, 15'd5, 15'd2, 15'd1);
    c = 0;
    while (!(valid_o && addr_o == 15'd17) && c < 20) begin @(negedge clk); c++; end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({addr_o, valid_o, z_o, last_o, busy_o, done_o} !== '0) begin
      n_err++;
      $display("FAIL mid_reset: addr=%h valid=%b z=%b last=%b busy=%b done=%b, want all 0",
               addr_o, valid_o, z_o, last_o, busy_o, done_o);
    end
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy_o, valid_o, done_o} !== 3'b000) begin
      n_err++;
      $display("FAIL post_reset: busy/valid/done=%b, want 000", {busy_o, valid_o, done_o});
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_backpressure;
    test_degenerate;
    test_abort;
    test_back_to_back;
    test_reset_mid_run;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
